seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 47 ++++
 rtl/bcd_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and BCD decode function for the scan driver and the legacy decoder.
package seg7_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    // Bit positions inside the {g,f,e,d,c,b,a} segment word
    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Non-BCD codes 10..15 render as blank
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        logic [SEG_W-1:0] s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, shared with the legacy parallel display path.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: one shared decoder, frame-synchronised loading,
// leading-zero blanking and per-digit blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS     = 3,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    blink_en,
    input  logic                    lzb_en,
    output logic [N_DIGITS-1:0]     an,
    output logic [SEG_W-1:0]        seg,
    output logic                    frame_start,
    output logic                    load_pending
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW = 4 * N_DIGITS;

    localparam logic [PW-1:0]       PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_MAX   = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0]       BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [DW-1:0]       staged_bcd;
    logic [N_DIGITS-1:0] staged_mask;
    logic [DW-1:0]       shadow_bcd;
    logic [N_DIGITS-1:0] shadow_mask;

    logic                tick;
    logic                boundary;
    logic                zero_run;
    logic [N_DIGITS-1:0] lz_blank;
    logic [BCD_W-1:0]    cur_bcd;
    logic                cur_blank;
    logic [SEG_W-1:0]    dec_seg;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    // Digit i>0 is a leading zero when it and every higher digit are zero
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_bcd[4*i +: 4] == 4'd0);
            if (i > 0) begin
                lz_blank[i] = lzb_en && zero_run;
            end
        end
    end

    always_comb begin
        cur_bcd   = '0;
        cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_bcd   = shadow_bcd[4*i +: 4];
                cur_blank = lz_blank[i] || (blink_en && shadow_mask[i] && blink_phase);
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // Scan timing and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            idx         <= '0;
            an          <= '0;
            seg         <= '0;
            frame_start <= 1'b0;
        end else begin
            presc       <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end
            frame_start <= boundary;
            an          <= AN_ONE << idx;
            seg         <= cur_blank ? SEG_BLANK : dec_seg;
        end
    end

    // Staged value is promoted only at the frame boundary so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            staged_bcd   <= '0;
            staged_mask  <= '0;
            shadow_bcd   <= '0;
            shadow_mask  <= '0;
            load_pending <= 1'b0;
        end else begin
            if (load) begin
                staged_bcd  <= bcd_in;
                staged_mask <= blink_mask;
            end
            if (boundary) begin
                load_pending <= 1'b0;
                if (load) begin
                    shadow_bcd  <= bcd_in;
                    shadow_mask <= blink_mask;
                end else if (load_pending) begin
                    shadow_bcd  <= staged_bcd;
                    shadow_mask <= staged_mask;
                end
            end else if (load) begin
                load_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (boundary) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with N_DIGITS=3, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [11:0] bcd_in;
    logic        load;
    logic [2:0]  blink_mask;
    logic        blink_en;
    logic        lzb_en;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        frame_start;
    logic        load_pending;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [11:0] bcd;
        logic [2:0]  mask;
        logic        lzb;
        logic [6:0]  s0;
        logic [6:0]  s1;
        logic [6:0]  s2;
    } vec_t;

    vec_t vecs [7];

    seg7_scan_driver #(
        .N_DIGITS     (3),
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bcd_in       (bcd_in),
        .load         (load),
        .blink_mask   (blink_mask),
        .blink_en     (blink_en),
        .lzb_en       (lzb_en),
        .an           (an),
        .seg          (seg),
        .frame_start  (frame_start),
        .load_pending (load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Returns at the negedge inside the next frame_start cycle
    task automatic wait_fs(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        chk({name, "_fs_seen"}, 32'(seen), 32'd1);
    endtask

    // Called from the frame_start cycle; checks first and last cycle of each slot
    task automatic check_slots(input string name, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2);
        logic [6:0] exp [3];
        exp = '{e0, e1, e2};
        for (int d = 0; d < 3; d++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_an%0d", name, d), 32'(an), 32'(3'b001 << d));
            chk($sformatf("%s_seg%0d", name, d), 32'(seg), 32'(exp[d]));
            repeat (2) @(posedge clk);
            @(posedge clk); #1;
            chk($sformatf("%s_an%0d_end", name, d), 32'(an), 32'(3'b001 << d));
        end
    endtask

    task automatic check_frame(input string name, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2);
        wait_fs(name);
        check_slots(name, e0, e1, e2);
    endtask

    task automatic do_load(input logic [11:0] b, input logic [2:0] m);
        @(negedge clk);
        bcd_in     = b;
        blink_mask = m;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    initial begin
        int period;
        bit got;

        vecs[0] = '{12'h259, 3'b000, 1'b0, 7'h6F, 7'h6D, 7'h5B};
        vecs[1] = '{12'h007, 3'b000, 1'b1, 7'h07, 7'h00, 7'h00};
        vecs[2] = '{12'h000, 3'b000, 1'b1, 7'h3F, 7'h00, 7'h00};
        vecs[3] = '{12'h070, 3'b000, 1'b1, 7'h3F, 7'h07, 7'h00};
        vecs[4] = '{12'h3AF, 3'b000, 1'b1, 7'h00, 7'h00, 7'h4F};
        vecs[5] = '{12'h105, 3'b000, 1'b1, 7'h6D, 7'h3F, 7'h06};
        vecs[6] = '{12'h468, 3'b111, 1'b0, 7'h7F, 7'h7D, 7'h66};

        rst_n = 1'b0; load = 1'b0; bcd_in = '0; blink_mask = '0;
        blink_en = 1'b0; lzb_en = 1'b0;

        // Reset state and release
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_pend", 32'(load_pending), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_an", 32'(an), 32'd1);
        chk("rel_seg", 32'(seg), 32'h3F);

        // Idle scan: frame period and all-zero display
        wait_fs("idle0");
        period = 0;
        got    = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            period++;
            if (frame_start) got = 1'b1;
        end
        chk("fs_period", 32'(period), 32'd12);
        check_slots("idle", 7'h3F, 7'h3F, 7'h3F);

        // Mid-frame load stays pending; current frame finishes unchanged
        repeat (4) @(negedge clk);
        do_load(12'h259, 3'b000);
        chk("mid_pend", 32'(load_pending), 32'd1);
        repeat (5) @(negedge clk);
        chk("mid_old_an", 32'(an), 32'b100);
        chk("mid_old_seg", 32'(seg), 32'h3F);
        chk("mid_old_pend", 32'(load_pending), 32'd1);
        check_frame("mid259", 7'h6F, 7'h6D, 7'h5B);
        chk("mid_pend_clr", 32'(load_pending), 32'd0);

        // Table-driven decode / leading-zero vectors
        for (int v = 0; v < 7; v++) begin
            lzb_en   = vecs[v].lzb;
            blink_en = 1'b0;
            do_load(vecs[v].bcd, vecs[v].mask);
            check_frame($sformatf("vec%0d", v), vecs[v].s0, vecs[v].s1, vecs[v].s2);
        end

        // Load in the exact boundary cycle goes straight to the display
        lzb_en = 1'b0;
        wait_fs("sync");
        repeat (11) @(negedge clk);
        bcd_in = 12'h999; blink_mask = 3'b000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_fs", 32'(frame_start), 32'd1);
        chk("bnd_pend", 32'(load_pending), 32'd0);
        check_slots("bnd999", 7'h6F, 7'h6F, 7'h6F);
        chk("bnd_pend_end", 32'(load_pending), 32'd0);

        // Two loads in one frame: latest wins
        do_load(12'h111, 3'b000);
        @(negedge clk);
        do_load(12'h222, 3'b000);
        check_frame("double", 7'h5B, 7'h5B, 7'h5B);

        // Blink: fresh reset so the blink phase schedule is known
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        blink_en = 1'b1;
        lzb_en   = 1'b0;
        do_load(12'h123, 3'b010);
        check_frame("blink1", 7'h4F, 7'h5B, 7'h06);
        check_frame("blink2", 7'h4F, 7'h00, 7'h06);
        check_frame("blink3", 7'h4F, 7'h00, 7'h06);
        check_frame("blink4", 7'h4F, 7'h5B, 7'h06);
        check_frame("blink5", 7'h4F, 7'h5B, 7'h06);
        blink_en = 1'b0;
        check_frame("blink6_off", 7'h4F, 7'h5B, 7'h06);

        // Reset mid-frame discards the pending load
        do_load(12'h456, 3'b000);
        @(negedge clk);
        chk("rst2_pend_before", 32'(load_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst2_an", 32'(an), 32'd0);
        chk("rst2_seg", 32'(seg), 32'd0);
        chk("rst2_pend", 32'(load_pending), 32'd0);
        chk("rst2_fs", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst2_rel_an", 32'(an), 32'd1);
        chk("rst2_rel_seg", 32'(seg), 32'h3F);
        check_frame("post_rst", 7'h3F, 7'h3F, 7'h3F);
        chk("post_rst_pend", 32'(load_pending), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
